// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// word size, default queue depth and a saturating-increment helper.
package fetch_pkg;

    typedef enum logic {
        RUN,
        END
    } fetch_state_t;

    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned DEFAULT_DEPTH = 4;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && value != '1) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch circular buffer; each entry holds {inst, pc_plus4}.
// clear empties the queue without touching stored data; rst also zeroes it.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_controller.sv
// Fetch sequencer: owns the PC, fills the prefetch queue, redirects on branches.
// Define FETCH_STATS_EN to add saturating fetch/stall/flush counters.
module fetch_queue_controller
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        in_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        done
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    localparam int unsigned   CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [31:0]   END_ADDR  = 32'(MEM_WORDS * WORD_BYTES);
    localparam logic [31:0]   LAST_ADDR = END_ADDR - 32'(WORD_BYTES);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   pc;
    logic [31:0]   pc_next;
    logic [31:0]   pc_plus4;
    logic [31:0]   target;
    logic [CW-1:0] count;
    logic [63:0]   rdata;
    logic          push;
    logic          pop;

    assign pc_plus4  = pc + 32'(WORD_BYTES);
    assign target    = branch_addr & ~32'd3;
    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_inst  = rdata[63:32];
    assign out_pc    = rdata[31:0];
    assign done      = (state == END) && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // A redirect flushes the queue, so the head in that cycle is dropped, not popped.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        pop        = out_valid && in_ready && !branch_taken;
        if (branch_taken) begin
            pc_next    = target;
            state_next = (target < END_ADDR) ? RUN : END;
        end else if (state == RUN && (count < FULL || pop)) begin
            push    = 1'b1;
            pc_next = pc_plus4;
            if (pc == LAST_ADDR) begin
                state_next = END;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (branch_taken),
        .wdata ({imem_inst, pc_plus4}),
        .rdata (rdata),
        .count (count)
    );

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            fetch_count <= sat_inc(fetch_count, push);
            stall_count <= sat_inc(stall_count, out_valid && !in_ready);
            flush_count <= sat_inc(flush_count, branch_taken);
        end
    end
`endif

endmodule
